// File: rtl/i2c_temp_read_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_temp_read_sequencer
//
// Periodic scheduler and byte sequencer for a shared I2C master. Every
// PERIOD_CYCLES clocks (or on a start_now request while idle) it runs one
// two-byte read from SENSOR_ADDR. Busy edges from the master mark the start
// and end of each byte. The MSB is parked in a hold register and both bytes
// are published together, so temp_msb/temp_lsb always belong to one sample.
//
// Ports:
//   clk            system clock, shared with the I2C master
//   reset          synchronous, active-high reset
//   start_now      one-cycle request for an immediate read (IDLE only)
//   i2c_ena        enable to the I2C master
//   i2c_addr       7-bit slave address (constant SENSOR_ADDR)
//   i2c_rw         read/write select (constant 1 = read)
//   i2c_busy       busy from the I2C master
//   i2c_data_rd    read data from the I2C master
//   i2c_ack_error  ack_error from the I2C master
//   temp_msb       last good MSB
//   temp_lsb       last good LSB
//   temp_valid     one-cycle pulse when temp_msb/temp_lsb update
//   rd_error       one-cycle pulse when a read fails (NACK or timeout)
//   seq_busy       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module i2c_temp_read_sequencer #(
    parameter int unsigned PERIOD_CYCLES  = 12500,
    parameter logic [6:0]  SENSOR_ADDR    = 7'b1001011,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_now,
    output logic       i2c_ena,
    output logic [6:0] i2c_addr,
    output logic       i2c_rw,
    input  logic       i2c_busy,
    input  logic [7:0] i2c_data_rd,
    input  logic       i2c_ack_error,
    output logic [7:0] temp_msb,
    output logic [7:0] temp_lsb,
    output logic       temp_valid,
    output logic       rd_error,
    output logic       seq_busy
);

    localparam int PCW = (PERIOD_CYCLES  > 1) ? $clog2(PERIOD_CYCLES)  : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_B1,
        S_RD_MSB,
        S_WAIT_B2,
        S_RD_LSB,
        S_DONE,
        S_ERR
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic           busy_q_reg;
    logic [PCW-1:0] period_cnt_reg;
    logic [TCW-1:0] wait_cnt_reg;
    logic [7:0]     hold_reg;
    logic [7:0]     temp_msb_reg;
    logic [7:0]     temp_lsb_reg;

    logic busy_rise;
    logic busy_fall;
    logic tick;
    logic timed_out;
    logic waiting;
    logic capture_msb;
    logic load_sample;

    assign busy_rise = i2c_busy & ~busy_q_reg;
    assign busy_fall = ~i2c_busy & busy_q_reg;
    assign tick      = (period_cnt_reg == PCW'(PERIOD_CYCLES - 1));
    assign timed_out = (wait_cnt_reg == TCW'(TIMEOUT_CYCLES - 1));
    assign waiting   = (state_reg == S_WAIT_B1) || (state_reg == S_RD_MSB) ||
                       (state_reg == S_WAIT_B2) || (state_reg == S_RD_LSB);

    assign i2c_addr = SENSOR_ADDR;
    assign i2c_rw   = 1'b1;
    assign temp_msb = temp_msb_reg;
    assign temp_lsb = temp_lsb_reg;
    assign seq_busy = (state_reg != S_IDLE);

    // Next-state and output decode. In every wait state a busy edge takes
    // priority over the timeout, so a late-but-real edge is never lost.
    always_comb begin
        state_next  = state_reg;
        i2c_ena     = 1'b0;
        temp_valid  = 1'b0;
        rd_error    = 1'b0;
        capture_msb = 1'b0;
        load_sample = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (tick || start_now) begin
                    state_next = S_WAIT_B1;
                end
            end
            S_WAIT_B1: begin
                i2c_ena = 1'b1;
                if (busy_rise) begin
                    state_next = S_RD_MSB;
                end else if (timed_out) begin
                    state_next = S_ERR;
                end
            end
            S_RD_MSB: begin
                i2c_ena = 1'b1;
                if (busy_fall) begin
                    if (i2c_ack_error) begin
                        state_next = S_ERR;
                    end else begin
                        capture_msb = 1'b1;
                        state_next  = S_WAIT_B2;
                    end
                end else if (timed_out) begin
                    state_next = S_ERR;
                end
            end
            S_WAIT_B2: begin
                // Dropping ena as soon as byte 2 starts tells the master
                // that this is the last byte, so it issues STOP afterwards.
                i2c_ena = ~busy_rise;
                if (busy_rise) begin
                    state_next = S_RD_LSB;
                end else if (timed_out) begin
                    state_next = S_ERR;
                end
            end
            S_RD_LSB: begin
                if (busy_fall) begin
                    if (i2c_ack_error) begin
                        state_next = S_ERR;
                    end else begin
                        load_sample = 1'b1;
                        state_next  = S_DONE;
                    end
                end else if (timed_out) begin
                    state_next = S_ERR;
                end
            end
            S_DONE: begin
                temp_valid = 1'b1;
                state_next = S_IDLE;
            end
            S_ERR: begin
                // Hold off until the master has released the bus.
                if (!i2c_busy) begin
                    rd_error   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            busy_q_reg     <= 1'b0;
            period_cnt_reg <= '0;
            wait_cnt_reg   <= '0;
            hold_reg       <= '0;
            temp_msb_reg   <= '0;
            temp_lsb_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            busy_q_reg <= i2c_busy;

            // Free-running period counter, independent of the FSM state.
            if (tick) begin
                period_cnt_reg <= '0;
            end else begin
                period_cnt_reg <= period_cnt_reg + PCW'(1);
            end

            // The wait counter restarts on each state entry so every wait
            // state gets its own full timeout budget.
            if (state_next != state_reg) begin
                wait_cnt_reg <= '0;
            end else if (waiting) begin
                wait_cnt_reg <= wait_cnt_reg + TCW'(1);
            end else begin
                wait_cnt_reg <= '0;
            end

            if (capture_msb) begin
                hold_reg <= i2c_data_rd;
            end

            if (load_sample) begin
                temp_msb_reg <= hold_reg;
                temp_lsb_reg <= i2c_data_rd;
            end
        end
    end

endmodule

// File: tb/tb_i2c_temp_read_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for i2c_temp_read_sequencer.
// A behavioural I2C master answers ena by raising busy for 8 cycles per byte
// and continuing to a second byte only while ena is still high at the end of
// the first. Expected samples, error pulses and start times come from the
// scheduling rules (tick every PERIOD cycles, timeout after TMO cycles).
// -----------------------------------------------------------------------------
module tb_i2c_temp_read_sequencer;

    localparam int PERIOD = 20;
    localparam int TMO    = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_now = 1'b0;
    logic       i2c_ena;
    logic [6:0] i2c_addr;
    logic       i2c_rw;
    logic       i2c_busy = 1'b0;
    logic [7:0] i2c_data_rd = 8'h00;
    logic       i2c_ack_error = 1'b0;
    logic [7:0] temp_msb;
    logic [7:0] temp_lsb;
    logic       temp_valid;
    logic       rd_error;
    logic       seq_busy;

    always #5 clk = ~clk;

    i2c_temp_read_sequencer #(
        .PERIOD_CYCLES (PERIOD),
        .SENSOR_ADDR   (7'b1001011),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_now    (start_now),
        .i2c_ena      (i2c_ena),
        .i2c_addr     (i2c_addr),
        .i2c_rw       (i2c_rw),
        .i2c_busy     (i2c_busy),
        .i2c_data_rd  (i2c_data_rd),
        .i2c_ack_error(i2c_ack_error),
        .temp_msb     (temp_msb),
        .temp_lsb     (temp_lsb),
        .temp_valid   (temp_valid),
        .rd_error     (rd_error),
        .seq_busy     (seq_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Cycles since reset release; its value mod PERIOD is the expected count.
    int since_rst = 0;
    always @(posedge clk) since_rst <= reset ? 0 : since_rst + 1;

    // ---------------- behavioural I2C master ----------------
    bit         mdl_on = 1'b1;
    bit         mdl_nack_first = 1'b0;
    logic [7:0] mdl_bytes [2];

    always begin : master
        int bidx;
        bit cont;
        bit nack;
        @(negedge clk);
        if (mdl_on && i2c_ena === 1'b1 && !reset) begin
            bidx = 0;
            cont = 1'b1;
            while (cont) begin
                @(negedge clk);
                i2c_busy      = 1'b1;
                i2c_ack_error = 1'b0;
                repeat (8) @(negedge clk);
                i2c_busy      = 1'b0;
                i2c_data_rd   = mdl_bytes[bidx];
                nack          = mdl_nack_first && (bidx == 0);
                i2c_ack_error = nack;
                cont          = (i2c_ena === 1'b1) && !nack && (bidx == 0);
                bidx++;
            end
        end
    end

    // ---------------- monitor ----------------
    int   valid_cnt = 0, err_cnt = 0, vrun = 0, vrun_max = 0, erun = 0, erun_max = 0;
    int   ena_rise_cnt = 0, ena_rise_s = 0, ena_run = 0, ena_last_run = 0;
    int   rise_idx = 0, err_s = 0, glitch_cnt = 0;
    logic ena_at_rise [2];
    logic ena_prev = 1'b0, busy_prev = 1'b0;
    logic [7:0] prev_msb = 8'h00, prev_lsb = 8'h00;

    always begin : monitor
        @(negedge clk);
        #1;
        if (i2c_ena === 1'b1 && ena_prev !== 1'b1) begin
            ena_rise_cnt++;
            ena_rise_s = since_rst;
            rise_idx   = 0;
            ena_run    = 0;
        end
        if (i2c_ena === 1'b1) ena_run++;
        else if (ena_prev === 1'b1) ena_last_run = ena_run;
        if (i2c_busy && !busy_prev) begin
            if (rise_idx < 2) ena_at_rise[rise_idx] = i2c_ena;
            rise_idx++;
        end
        if (temp_valid === 1'b1) begin valid_cnt++; vrun++; end else vrun = 0;
        if (vrun > vrun_max) vrun_max = vrun;
        if (rd_error === 1'b1) begin err_cnt++; erun++; err_s = since_rst; end else erun = 0;
        if (erun > erun_max) erun_max = erun;
        if (since_rst != 0 && temp_valid !== 1'b1 &&
            (temp_msb !== prev_msb || temp_lsb !== prev_lsb)) glitch_cnt++;
        prev_msb  = temp_msb;
        prev_lsb  = temp_lsb;
        ena_prev  = i2c_ena;
        busy_prev = i2c_busy;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ena_rise(input int budget, input string tag);
        int c0 = ena_rise_cnt;
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (ena_rise_cnt != c0) begin ok = 1'b1; break; end
        end
        check({tag, "_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_result(input int budget, input string tag);
        int v = valid_cnt;
        int e = err_cnt;
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (valid_cnt != v || err_cnt != e) begin ok = 1'b1; break; end
        end
        check({tag, "_done"}, 32'(ok), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int         t0, v0, e0, k;
        logic [7:0] exp_msb, exp_lsb, b0, b1;
        bit         nk;

        mdl_bytes[0] = 8'h19;
        mdl_bytes[1] = 8'h80;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_ena",   32'(i2c_ena), 0);
        check("rst_msb",   32'(temp_msb), 0);
        check("rst_lsb",   32'(temp_lsb), 0);
        check("rst_valid", 32'(temp_valid), 0);
        check("rst_err",   32'(rd_error), 0);
        check("rst_seq",   32'(seq_busy), 0);
        check("addr",      32'(i2c_addr), 32'h4B);
        check("rw",        32'(i2c_rw), 1);
        @(negedge clk);
        reset = 1'b0;

        // First read: starts the cycle after count = PERIOD-1
        wait_ena_rise(40, "first_ena");
        check("first_ena_s", 32'(ena_rise_s), PERIOD);
        wait_result(60, "read1");
        check("read1_msb", 32'(temp_msb), 32'h19);
        check("read1_lsb", 32'(temp_lsb), 32'h80);
        check("ena_at_rise1", 32'(ena_at_rise[0]), 1);
        check("ena_at_rise2", 32'(ena_at_rise[1]), 0);
        exp_msb = 8'h19;
        exp_lsb = 8'h80;

        // NACK on the first byte; no extra read within the period
        mdl_nack_first = 1'b1;
        t0 = ena_rise_s;
        v0 = valid_cnt;
        e0 = err_cnt;
        wait_ena_rise(60, "nack_ena");
        check("nack_ena_gap", 32'(ena_rise_s - t0), 2 * PERIOD);
        wait_result(60, "nack");
        check("nack_err_cnt", 32'(err_cnt - e0), 1);
        check("nack_err_delay", 32'(err_s - ena_rise_s), 10);
        check("nack_valid", 32'(valid_cnt - v0), 0);
        check("nack_msb", 32'(temp_msb), 32'(exp_msb));
        check("nack_lsb", 32'(temp_lsb), 32'(exp_lsb));

        // Master never answers: timeout after TMO cycles in the first wait
        mdl_nack_first = 1'b0;
        mdl_on = 1'b0;
        wait_ena_rise(60, "tmo_ena");
        t0 = ena_rise_s;
        v0 = valid_cnt;
        wait_result(120, "tmo");
        check("tmo_err_delay", 32'(err_s - t0), TMO);
        check("tmo_ena_len", 32'(ena_last_run), TMO);
        check("tmo_valid", 32'(valid_cnt - v0), 0);
        check("tmo_msb", 32'(temp_msb), 32'(exp_msb));

        // Recovery on the next tick with random data
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        mdl_bytes[0] = b0;
        mdl_bytes[1] = b1;
        mdl_on = 1'b1;
        wait_ena_rise(60, "rec_ena");
        check("rec_ena_gap", 32'(ena_rise_s - t0), 4 * PERIOD);
        wait_result(60, "rec");
        exp_msb = b0;
        exp_lsb = b1;
        check("rec_msb", 32'(temp_msb), 32'(exp_msb));
        check("rec_lsb", 32'(temp_lsb), 32'(exp_lsb));

        // start_now in IDLE at count 5; later start_now and tick are dropped
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        mdl_bytes[0] = b0;
        mdl_bytes[1] = b1;
        k = 0;
        while (k < 60 && !((since_rst % PERIOD) == 5 && seq_busy === 1'b0)) begin
            @(negedge clk);
            k++;
        end
        check("sn_slot_found", 32'(k < 60), 1);
        t0 = since_rst;
        start_now = 1'b1;
        @(negedge clk);
        start_now = 1'b0;
        wait_ena_rise(5, "sn_ena");
        check("sn_ena_s", 32'(ena_rise_s), 32'(t0 + 1));
        t0 = ena_rise_s;
        v0 = valid_cnt;
        repeat (6) @(negedge clk);
        start_now = 1'b1;
        @(negedge clk);
        start_now = 1'b0;
        wait_ena_rise(60, "sn_next");
        check("sn_next_gap", 32'(ena_rise_s - t0), 34);
        check("sn_valid_count", 32'(valid_cnt - v0), 1);
        check("sn_msb", 32'(temp_msb), 32'(b0));
        check("sn_lsb", 32'(temp_lsb), 32'(b1));

        // Reset while the first byte is in flight
        k = 0;
        while (k < 20 && rise_idx < 1) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("mid_rise_found", 32'(rise_idx >= 1), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        v0 = valid_cnt;
        e0 = err_cnt;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("mid_rst_ena", 32'(i2c_ena), 0);
        check("mid_rst_seq", 32'(seq_busy), 0);
        check("mid_rst_msb", 32'(temp_msb), 0);
        check("mid_rst_lsb", 32'(temp_lsb), 0);
        repeat (15) @(negedge clk);
        #2;
        check("mid_rst_novalid", 32'(valid_cnt - v0), 0);
        check("mid_rst_noerr", 32'(err_cnt - e0), 0);
        exp_msb = 8'h00;
        exp_lsb = 8'h00;

        // Randomized reads, some NACKed
        for (int i = 0; i < 6; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            nk = ($urandom_range(0, 3) == 0);
            mdl_bytes[0] = b0;
            mdl_bytes[1] = b1;
            mdl_nack_first = nk;
            v0 = valid_cnt;
            e0 = err_cnt;
            wait_ena_rise(60, "rnd_ena");
            check("rnd_ena_pc", 32'(ena_rise_s % PERIOD), 0);
            wait_result(60, "rnd");
            if (!nk) begin
                exp_msb = b0;
                exp_lsb = b1;
            end
            check("rnd_valid_inc", 32'(valid_cnt - v0), nk ? 0 : 1);
            check("rnd_err_inc", 32'(err_cnt - e0), nk ? 1 : 0);
            check("rnd_msb", 32'(temp_msb), 32'(exp_msb));
            check("rnd_lsb", 32'(temp_lsb), 32'(exp_lsb));
        end
        mdl_nack_first = 1'b0;

        // Whole-run properties
        check("valid_width", 32'(vrun_max), 1);
        check("err_width", 32'(erun_max), 1);
        check("coherent_update", 32'(glitch_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
